// File: rtl/psum_writeback_if.sv
// Beat input and ofmap write bus of the partial-sum writeback stage.
interface psum_writeback_if #(
  parameter int ADDR_W = 10
);
  logic               wb_en;
  logic signed [10:0] gsum1;
  logic signed [10:0] gsum2;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [15:0]        mem_wdata;

  modport master (output wb_en, gsum1, gsum2, input mem_we, mem_addr, mem_wdata);
  modport slave  (input wb_en, gsum1, gsum2, output mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/psum_writeback.sv
// Partial-sum writeback: accumulates PE group sums across passes, requantizes the
// final pass to int8 and writes pixel pairs to the ofmap SRAM.
module psum_writeback #(
  parameter int PIX_NUM = 64,
  parameter int ADDR_W  = 10,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        pass_num,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        layer,
  input  logic              relu_en,
  input  logic [2:0]        shift,
  psum_writeback_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PIX_W = $clog2(PIX_NUM);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                  state, state_next;
  logic [3:0]              pass_last, pass_cnt;
  logic [ADDR_W-1:0]       base_q, wofs, s1_addr;
  logic                    single_q, relu_q;
  logic [2:0]              shift_q;
  logic [PIX_W-1:0]        pix, idx1;
  logic                    full;
  logic [7:0]              lo_byte, q0, q1;
  logic                    s1_we, s1_last, out_last;
  logic [15:0]             s1_word, word;
  logic signed [ACC_W-1:0] acc_buf [PIX_NUM];
  logic signed [ACC_W-1:0] new0, new1;
  logic                    beat, last_pix, first_pass, final_pass, emit;

  // First pass overwrites the entry; later passes add with saturation.
  function automatic logic signed [ACC_W-1:0] accum(input logic signed [ACC_W-1:0] old,
                                                    input logic signed [10:0]      g,
                                                    input logic                    first);
    logic signed [ACC_W:0] a, b, s;
    a = old;
    b = g;
    s = a + b;
    if (first) return ACC_W'(g);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] v,
                                         input logic                    relu,
                                         input logic [2:0]              sh);
    logic signed [ACC_W-1:0] r, q;
    r = (relu && v[ACC_W-1]) ? '0 : v;
    q = r >>> sh;
    if (q > Q_MAX) return 8'h7f;
    if (q < Q_MIN) return 8'h80;
    return q[7:0];
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    beat       = bus.wb_en && (state == S_ACCUM) && !start && !full;
    idx1       = single_q ? pix : pix + PIX_W'(1);
    last_pix   = single_q ? (pix == PIX_W'(PIX_NUM - 1)) : (pix == PIX_W'(PIX_NUM - 2));
    first_pass = (pass_cnt == 4'd0);
    final_pass = (pass_cnt == pass_last);
    new0       = accum(acc_buf[pix],  bus.gsum1, first_pass);
    new1       = accum(acc_buf[idx1], bus.gsum2, first_pass);
    q0         = requant(new0, relu_q, shift_q);
    q1         = requant(new1, relu_q, shift_q);
    // Single-lane words complete on the odd pixel; dual-lane beats always complete one.
    emit       = beat && final_pass && (!single_q || pix[0]);
    word       = single_q ? {q0, lo_byte} : {q1, q0};
  end

  // NOTE: the pixel buffer is plain storage with no reset; the first pass always
  // overwrites each entry before it is read back.
  always_ff @(posedge clk) begin
    if (beat) begin
      acc_buf[pix] <= new0;
      if (!single_q) acc_buf[idx1] <= new1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_ACCUM;
      S_ACCUM: begin
        busy = 1'b1;
        if (out_last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (start) state_next = S_ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_last     <= '0;
      pass_cnt      <= '0;
      base_q        <= '0;
      single_q      <= 1'b0;
      relu_q        <= 1'b0;
      shift_q       <= '0;
      pix           <= '0;
      wofs          <= '0;
      full          <= 1'b0;
      lo_byte       <= '0;
      err           <= 1'b0;
      s1_we         <= 1'b0;
      s1_last       <= 1'b0;
      s1_addr       <= '0;
      s1_word       <= '0;
      out_last      <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // A start aborts any write still in flight from the previous tile.
      bus.mem_we    <= s1_we && !start;
      bus.mem_addr  <= s1_addr;
      bus.mem_wdata <= s1_word;
      out_last      <= s1_last && !start;
      s1_we         <= 1'b0;
      s1_last       <= 1'b0;
      if (start) begin
        pass_last <= (pass_num == 4'd0) ? 4'd0 : pass_num - 4'd1;
        base_q    <= base_addr;
        single_q  <= (layer == 4'd1);
        relu_q    <= relu_en;
        shift_q   <= shift;
        pass_cnt  <= '0;
        pix       <= '0;
        wofs      <= '0;
        full      <= 1'b0;
        err       <= 1'b0;
      end else begin
        if (bus.wb_en && state != S_ACCUM) err <= 1'b1;
        if (beat) begin
          if (last_pix) begin
            pix <= '0;
            if (final_pass) full     <= 1'b1;
            else            pass_cnt <= pass_cnt + 4'd1;
          end else begin
            pix <= pix + (single_q ? PIX_W'(1) : PIX_W'(2));
          end
          if (single_q && !pix[0]) lo_byte <= q0;
          if (emit) begin
            s1_we   <= 1'b1;
            s1_last <= last_pix;
            s1_addr <= base_q + wofs;
            s1_word <= word;
            wofs    <= wofs + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized bench for psum_writeback with an integer reference model and a
// write scoreboard checked on the falling edge.
module tb_psum_writeback;
  localparam int PIX_NUM = 64;
  localparam int ADDR_W  = 10;
  // Narrow accumulator so that both saturation rails are reachable with 11-bit sums.
  localparam int ACC_W   = 12;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        pass_num = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [3:0]        layer = '0;
  logic              relu_en = 1'b0;
  logic [2:0]        shift = '0;
  logic              busy, done, err;

  psum_writeback_if #(.ADDR_W(ADDR_W)) bus ();

  psum_writeback #(.PIX_NUM(PIX_NUM), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pass_num  (pass_num),
    .base_addr (base_addr),
    .layer     (layer),
    .relu_en   (relu_en),
    .shift     (shift),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, want);
    end
  endtask

  // Reference model state
  wr_t        exp_q[$];
  int         macc [PIX_NUM];
  int         m_pass, m_pix, m_passes, m_shift, m_wcnt, m_base;
  bit         m_single, m_relu;
  logic [7:0] m_held;

  function automatic int rg();
    return int'($urandom_range(2047)) - 1024;
  endfunction

  function automatic logic [7:0] rq(input int v_in);
    int v;
    v = (m_relu && v_in < 0) ? 0 : v_in;
    v = v >>> m_shift;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  function automatic void push_word(input logic [7:0] hi, input logic [7:0] lo);
    wr_t w;
    w.addr = ADDR_W'(m_base + m_wcnt);
    w.data = {hi, lo};
    exp_q.push_back(w);
    m_wcnt++;
  endfunction

  function automatic void model_beat(input int g1, input int g2);
    int lanes, g, s;
    lanes = m_single ? 1 : 2;
    for (int l = 0; l < lanes; l++) begin
      g = (l == 0) ? g1 : g2;
      s = macc[m_pix + l] + g;
      if (s > ACC_MAX) s = ACC_MAX;
      if (s < ACC_MIN) s = ACC_MIN;
      macc[m_pix + l] = (m_pass == 0) ? g : s;
    end
    if (m_pass == m_passes - 1) begin
      if (!m_single)          push_word(rq(macc[m_pix + 1]), rq(macc[m_pix]));
      else if (m_pix % 2 == 1) push_word(rq(macc[m_pix]), m_held);
      else                     m_held = rq(macc[m_pix]);
    end
    m_pix += lanes;
    if (m_pix >= PIX_NUM) begin
      m_pix = 0;
      m_pass++;
    end
  endfunction

  // Write and done monitor
  int                cyc = 0;
  int                last_we_cyc = -10;
  int                n_done = 0;
  logic [15:0]       last_wdata = '0;
  logic [ADDR_W-1:0] last_waddr = '0;
  wr_t               mon_w;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_we === 1'b1) begin
      last_we_cyc = cyc;
      last_wdata  = bus.mem_wdata;
      last_waddr  = bus.mem_addr;
      if (exp_q.size() == 0) begin
        check("write_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(mon_w.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(mon_w.data));
      end
    end
    if (done === 1'b1) begin
      n_done++;
      check("done_after_write", 32'(cyc), 32'(last_we_cyc + 1));
      check("busy_low_at_done", 32'(busy), 32'd0);
    end
  end

  // Driver tasks; each starts and ends 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_tile(input int pn, input int lay, input bit relu, input int sh,
                            input int base, input bit collide);
    pass_num    = 4'(pn);
    layer       = 4'(lay);
    relu_en     = relu;
    shift       = 3'(sh);
    base_addr   = ADDR_W'(base);
    start       = 1'b1;
    bus.wb_en   = collide;
    bus.gsum1   = 11'(rg());
    bus.gsum2   = 11'(rg());
    @(posedge clk);
    #1;
    start     = 1'b0;
    bus.wb_en = 1'b0;
    exp_q.delete();
    m_passes = (pn == 0) ? 1 : pn;
    m_single = (lay == 1);
    m_relu   = relu;
    m_shift  = sh;
    m_base   = base;
    m_pass   = 0;
    m_pix    = 0;
    m_wcnt   = 0;
  endtask

  task automatic beat(input int g1, input int g2);
    bus.wb_en = 1'b1;
    bus.gsum1 = 11'(g1);
    bus.gsum2 = 11'(g2);
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
    model_beat(g1, g2);
  endtask

  task automatic run_tile(input int pn, input int lay, input bit relu, input int sh,
                          input int base, input bit rnd, input int g1c, input int g2c,
                          input bit gaps, input bit collide);
    int passes = (pn == 0) ? 1 : pn;
    int lanes  = (lay == 1) ? 1 : 2;
    int d0     = n_done;
    int waited = 0;
    begin_tile(pn, lay, relu, sh, base, collide);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < PIX_NUM / lanes; i++) begin
        if (gaps && $urandom_range(3) == 0) idle(int'($urandom_range(1, 2)));
        beat(rnd ? rg() : g1c, rnd ? rg() : g2c);
      end
    end
    while (n_done == d0 && waited < 20) begin
      idle(1);
      waited++;
    end
    idle(3);
    check("done_once", 32'(n_done - d0), 32'd1);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after_tile", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.wb_en = 1'b0;
    bus.gsum1 = '0;
    bus.gsum2 = '0;
    #1 rst = 1'b1;
    idle(3);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err),  32'd0);
    check("rst_we",    32'(bus.mem_we),    32'd0);
    check("rst_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;
    idle(2);

    // Dual lane, constant sums, contiguous beats
    run_tile(1, 0, 0, 0, 'h10, 0, 5, -3, 0, 0);
    check("tp1_word", 32'(last_wdata), 32'hFD05);
    check("tp1_last_addr", 32'(last_waddr), 32'h2F);

    // Single lane, three passes, saturating requant
    run_tile(3, 1, 0, 1, 'h40, 0, 100, -777, 1, 0);
    check("tp2_word", 32'(last_wdata), 32'h7F7F);

    // ReLU before shift
    run_tile(1, 0, 1, 2, 'h80, 0, -50, 40, 1, 0);
    check("tp3_word", 32'(last_wdata), 32'h0A00);

    // Accumulator saturation, positive and negative rails
    run_tile(15, 2, 0, 7, 'h100, 0, 1023, 1023, 0, 0);
    check("sat_pos_word", 32'(last_wdata), 32'h0F0F);
    run_tile(6, 0, 0, 0, 'h180, 0, -1024, -1024, 1, 0);
    check("sat_neg_word", 32'(last_wdata), 32'h8080);

    // Abort after 10 beats of a two-pass tile, then a clean tile
    begin_tile(2, 0, 0, 0, 'h200, 0);
    repeat (10) beat(rg(), rg());
    run_tile(1, 0, 0, 3, 'h220, 1, 0, 0, 1, 0);

    // Beat outside ACCUM sets err; a start with a colliding beat clears it
    bus.wb_en = 1'b1;
    idle(1);
    bus.wb_en = 1'b0;
    check("err_set_idle", 32'(err), 32'd1);
    run_tile(2, 1, 1, 2, 'h240, 1, 0, 0, 1, 1);
    check("err_cleared", 32'(err), 32'd0);

    // Randomized tiles
    for (int t = 0; t < 5; t++)
      run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 900)), 1, 0, 0, 1, 0);

    // Reset during a write cycle
    begin_tile(1, 0, 0, 0, 'h300, 0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      beat(rg(), rg());
      if (bus.mem_we === 1'b1) seen = 1;
    end
    check("rst_write_reached", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_we",    32'(bus.mem_we),    32'd0);
    check("midrst_addr",  32'(bus.mem_addr),  32'd0);
    check("midrst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_done",  32'(done), 32'd0);
    check("midrst_err",   32'(err),  32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    run_tile(2, 0, 0, 1, 'h320, 1, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
